ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage that consumes the operand and control outputs of the ID/EX pipeline register. It implements MIPS32 MULT, MULTU, DIV and DIVU: it holds a start request, runs a 32-step shift-add multiply or restoring divide, and commits the result to architectural HI/LO. While running, it raises `busy` so hazard logic can stall IF/ID and hold ID/EX.

---
 rtl/ex_muldiv_pkg.sv | 18 +
 rtl/ex_muldiv.sv | 156 +++++++++++++++
 tb/tb_ex_muldiv.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide unit.
// Op codes match the ID/EX control field driving ex_muldiv.
package ex_muldiv_pkg;

    localparam int MULDIV_ITERS = 32;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO after 32 steps.
// Operands run as magnitudes; signs are restored in the FIX state.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] r_data1,
    input  logic [WIDTH-1:0] r_data2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t state_q, state_d;

    logic [5:0]         cnt_q;
    logic [1:0]         op_q;
    logic               sa_q;
    logic               neg_q;
    logic               bzero_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic               is_div;
    logic               signed_op;
    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   hi_d, lo_d;

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Flush outranks start even in IDLE: a squashed instruction never launches.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start && !flush) state_d = ST_RUN;
            ST_RUN: begin
                if (flush)
                    state_d = ST_IDLE;
                else if (cnt_q == 6'(MULDIV_ITERS - 1))
                    state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        sa        = signed_op & r_data1[WIDTH-1];
        sb        = signed_op & r_data2[WIDTH-1];
        mag_a     = sa ? -r_data1 : r_data1;
        mag_b     = sb ? -r_data2 : r_data2;
    end

    // acc holds {product_hi, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU);
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - b_q;
        if (!is_div)
            acc_step = {sum, acc_q[WIDTH-1:1]};
        else if (shifted >= {1'b0, b_q})
            acc_step = {diff, acc_q[WIDTH-2:0], 1'b1};
        else
            acc_step = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        hi_d     = prod_fix[2*WIDTH-1:WIDTH];
        lo_d     = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (bzero_q) begin
                hi_d = a_raw_q;
                lo_d = {WIDTH{1'b1}};
            end else begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            neg_q   <= 1'b0;
            bzero_q <= 1'b0;
            a_raw_q <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !flush) begin
                        op_q    <= op;
                        sa_q    <= sa;
                        neg_q   <= sa ^ sb;
                        bzero_q <= (r_data2 == '0);
                        a_raw_q <= r_data1;
                        b_q     <= mag_b;
                        acc_q   <= {{WIDTH{1'b0}}, mag_a};
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 6'd1;
                end
                ST_FIX: begin
                    if (!flush) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: arithmetic reference model plus directed vectors.
// Model tracks only "pending result due at cycle N", not the unit's FSM.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] r_data1 = '0;
    logic [31:0] r_data2 = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    always #5 clock = ~clock;

    ex_muldiv #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .r_data1(r_data1), .r_data2(r_data2), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Returns {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model_res(input logic [1:0] o,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (o)
            OP_MULT:  res = 64'(sa * sb);
            OP_MULTU: res = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (o == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {a % b, a / b};
                end
            end
        endcase
        return res;
    endfunction

    int          cyc = 0;
    int          due = 0;
    bit          pend = 0;
    bit          exp_done = 0;
    bit          checking = 0;
    logic [1:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always @(posedge clock) begin
        cyc++;
        exp_done = 0;
        if (reset) begin
            pend = 0;
            exp_hi = '0;
            exp_lo = '0;
        end else if (flush) begin
            pend = 0;
        end else if (pend) begin
            if (cyc == due) begin
                {exp_hi, exp_lo} = model_res(m_op, m_a, m_b);
                exp_done = 1;
                pend = 0;
            end
        end else if (start) begin
            pend = 1;
            due = cyc + 33;
            m_op = op;
            m_a = r_data1;
            m_b = r_data2;
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            check("cyc_busy", 64'(busy), 64'(pend));
            check("cyc_done", 64'(done), 64'(exp_done));
            check("cyc_hi", 64'(hi), 64'(exp_hi));
            check("cyc_lo", 64'(lo), 64'(exp_lo));
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        start = 1'b1;
        op = o;
        r_data1 = a;
        r_data2 = b;
        @(negedge clock);
        start = 1'b0;
    endtask

    // n counts negedges since the issuing negedge; done expected at n=34.
    task automatic wait_done(input int n0, output int nd, output int nb);
        nd = 0;
        nb = 0;
        for (int n = n0; n <= n0 + 60; n++) begin
            if (done) begin
                nd = n;
                break;
            end
            if (busy) nb++;
            @(negedge clock);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int nd, nb;
        issue(o, a, b);
        wait_done(1, nd, nb);
        check({name, "_lat"}, 64'(nd - 1), 64'd33);
        check({name, "_busy"}, 64'(nb), 64'd33);
        check({name, "_hi"}, 64'(hi), 64'(ehi));
        check({name, "_lo"}, 64'(lo), 64'(elo));
    endtask

    initial begin
        int nd, nb;
        repeat (2) @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        checking = 1;
        @(negedge clock);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0,
               32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000);
        run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000);
        run_op("div_negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_zero", OP_DIV, 32'hFFFF_FFF8, 32'd0,
               32'hFFFF_FFF8, 32'hFFFF_FFFF);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd1,
               32'h0000_0000, 32'hFFFF_FFFF);

        // Re-presented start while busy must be ignored.
        issue(OP_DIVU, 32'd10, 32'd3);
        repeat (9) @(negedge clock);
        issue(OP_MULTU, 32'd50, 32'd7);
        wait_done(11, nd, nb);
        check("restart_lat", 64'(nd - 1), 64'd33);
        check("restart_hi", 64'(hi), 64'd1);
        check("restart_lo", 64'(lo), 64'd3);

        // Next acceptance at k+34, right after done.
        issue(OP_MULTU, 32'd2, 32'd2);
        check("accept_k34", 64'(busy), 64'd1);
        wait_done(1, nd, nb);
        check("mul22_hi", 64'(hi), 64'd0);
        check("mul22_lo", 64'(lo), 64'd4);

        // Flush sampled at edge k+20.
        issue(OP_MULTU, 32'd7, 32'd9);
        repeat (19) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hi", 64'(hi), 64'd0);
        check("flush_lo", 64'(lo), 64'd4);
        repeat (20) @(negedge clock);
        check("flush_late_lo", 64'(lo), 64'd4);

        // Reset sampled at edge k+15 of a DIV.
        issue(OP_DIV, 32'd1000, 32'hFFFF_FFF9);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);

        run_op("mult_m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h0000_0001);
        run_op("div_1000", OP_DIV, 32'd1000, 32'hFFFF_FFF9,
               32'h0000_0006, 32'hFFFF_FF72);

        repeat (2) @(negedge clock);
        checking = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
